// File: rtl/as_uart_pkg.sv
// as_uart shared definitions: FSM encodings and frame geometry.
package as_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/as_uart_rx.sv
// as_uart receiver: synchroniser, 16x oversampled 8N1 deframer and
// single-byte holding register feeding the AS handshake.
module as_uart_rx
    import as_uart_pkg::*;
#(
    parameter int BAUD_DIV  = 27,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] as_data_o,
    output logic       as_dstrb_o,
    input  logic       as_busy_i,
    output logic       rx_frame_err_o,
    output logic       rx_overflow_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(BAUD_DIV - 1);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           sub_q, sub_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 dstrb_q, dstrb_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic                 rxs, tick, deliver, xfer;

    assign rxs  = sync_q[1];
    assign tick = (div_q == DIV_LAST);
    assign xfer = dstrb_q & ~as_busy_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            div_q   <= '0;
            sub_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dstrb_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_i};
            div_q   <= div_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dstrb_q <= dstrb_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        sub_d   = tick ? sub_q + 1'b1 : sub_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                div_d = '0;
                sub_d = '0;
                if (!rxs) state_d = RX_START;
            end
            RX_START: begin
                if (tick && sub_q == 4'(MID_SAMPLE - 1)) begin
                    sub_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && sub_q == 4'(OVERSAMPLE - 1)) begin
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && sub_q == 4'(OVERSAMPLE - 1)) begin
                    deliver = rxs;
                    ferr_d  = ~rxs;
                    state_d = rxs ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                div_d = '0;
                sub_d = '0;
                if (rxs) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // a delivery may reuse the slot in the same cycle it is drained
    always_comb begin
        data_d  = data_q;
        dstrb_d = dstrb_q & ~xfer;
        ovf_d   = 1'b0;
        if (deliver) begin
            if (!dstrb_q || xfer) begin
                data_d  = shift_q;
                dstrb_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign as_data_o      = data_q;
    assign as_dstrb_o     = dstrb_q;
    assign rx_frame_err_o = ferr_q;
    assign rx_overflow_o  = ovf_q;

endmodule

// File: rtl/as_uart.sv
// as_uart top: 8N1 transceiver bridging a serial line to the AS
// byte-stream handshake; transmitter lives here, receiver in as_uart_rx.
module as_uart
    import as_uart_pkg::*;
#(
    parameter int BAUD_DIV  = 27,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] as_data_o,
    output logic       as_dstrb_o,
    input  logic       as_busy_i,
    input  logic [7:0] as_data_i,
    input  logic       as_dstrb_i,
    output logic       as_busy_o,
    output logic       rx_frame_err_o,
    output logic       rx_overflow_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(BAUD_DIV - 1);

    tx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           sub_q, sub_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tick, bit_end, accept;

    as_uart_rx #(
        .BAUD_DIV  (BAUD_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .rx_i           (rx_i),
        .as_data_o      (as_data_o),
        .as_dstrb_o     (as_dstrb_o),
        .as_busy_i      (as_busy_i),
        .rx_frame_err_o (rx_frame_err_o),
        .rx_overflow_o  (rx_overflow_o)
    );

    assign tick    = (div_q == DIV_LAST);
    assign bit_end = tick && (sub_q == 4'(OVERSAMPLE - 1));
    assign accept  = as_dstrb_i & ~busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            sub_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        sub_d   = tick ? sub_q + 1'b1 : sub_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            TX_IDLE: begin
                div_d = '0;
                sub_d = '0;
                tx_d  = 1'b1;
                if (accept) begin
                    shift_d = as_data_i;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shift_q[1];
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
        busy_d = (state_d != TX_IDLE);
    end

    assign tx_o      = tx_q;
    assign as_busy_o = busy_q;

endmodule

// File: tb/tb_as_uart.sv
// Randomised self-checking bench for as_uart at BAUD_DIV=4 (64 clk/bit).
module tb_as_uart;

    localparam int BD  = 4;
    localparam int BIT = 16 * BD;
    localparam int FRM = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_i = 1'b1;
    logic       as_busy_i = 1'b0;
    logic       as_dstrb_i = 1'b0;
    logic [7:0] as_data_i = 8'h00;
    logic       tx_o, as_dstrb_o, as_busy_o;
    logic       rx_frame_err_o, rx_overflow_o;
    logic [7:0] as_data_o;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] got[$];
    int got_rd = 0;
    int dstrb_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
    logic txw[$];
    logic bzw[$];

    as_uart #(.BAUD_DIV(BD), .DIV_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_i           (rx_i),
        .tx_o           (tx_o),
        .as_data_o      (as_data_o),
        .as_dstrb_o     (as_dstrb_o),
        .as_busy_i      (as_busy_i),
        .as_data_i      (as_data_i),
        .as_dstrb_i     (as_dstrb_i),
        .as_busy_o      (as_busy_o),
        .rx_frame_err_o (rx_frame_err_o),
        .rx_overflow_o  (rx_overflow_o)
    );

    always #5 clk = ~clk;

    // AS-side observer: collects transferred bytes and pulse counts
    always @(negedge clk) begin
        if (!reset) begin
            if (as_dstrb_o && !as_busy_i) got.push_back(as_data_o);
            if (as_dstrb_o) dstrb_cnt++;
            if (rx_frame_err_o) ferr_cnt++;
            if (rx_overflow_o) ovf_cnt++;
        end
    end

    // ideal line level k cycles after the start bit begins
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int i;
        i = k / BIT;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic rx_drive(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input int stop_low);
        rx_drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) rx_drive(b[i], BIT);
        if (stop_low > 0) rx_drive(1'b0, stop_low * BIT);
        rx_drive(1'b1, BIT);
    endtask

    task automatic cap(input int n);
        txw.delete();
        bzw.delete();
        repeat (n) begin
            @(negedge clk);
            txw.push_back(tx_o);
            bzw.push_back(as_busy_o);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_o); end
        n_chk++; if (as_dstrb_o !== 1'b0) begin n_fail++; $display("FAIL reset_dstrb got %b want 0", as_dstrb_o); end
        n_chk++; if (as_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", as_busy_o); end
        n_chk++; if (rx_frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", rx_frame_err_o); end
        n_chk++; if (rx_overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", rx_overflow_o); end
        @(posedge clk);
        #1 reset = 1'b0;
        rx_drive(1'b1, 8);
    endtask

    task automatic test_rx_random;
        logic [7:0] b;
        int d0, f0, o0, g0;
        for (int n = 0; n < 5; n++) begin
            b = (n == 0) ? 8'hA5 : 8'($urandom);
            d0 = dstrb_cnt; f0 = ferr_cnt; o0 = ovf_cnt; g0 = got.size();
            rx_frame(b, 0);
            rx_drive(1'b1, 16);
            n_chk++; if (got.size() - g0 !== 1) begin n_fail++; $display("FAIL rx_count got %0d want 1", got.size() - g0); end
            else begin
                n_chk++; if (got[got_rd] !== b) begin n_fail++; $display("FAIL rx_data got %h want %h", got[got_rd], b); end
            end
            got_rd = got.size();
            n_chk++; if (dstrb_cnt - d0 !== 1) begin n_fail++; $display("FAIL rx_dstrb_len got %0d want 1", dstrb_cnt - d0); end
            n_chk++; if (ferr_cnt - f0 + ovf_cnt - o0 !== 0) begin n_fail++; $display("FAIL rx_err got %0d want 0", ferr_cnt - f0 + ovf_cnt - o0); end
        end
    endtask

    task automatic test_tx;
        logic [7:0] b;
        int bad;
        for (int n = 0; n < 3; n++) begin
            b = (n == 0) ? 8'h3C : 8'($urandom);
            n_chk++; if (as_busy_o !== 1'b0) begin n_fail++; $display("FAIL tx_idle_busy got %b want 0", as_busy_o); end
            as_data_i = b;
            as_dstrb_i = 1'b1;
            @(posedge clk);
            #1 as_dstrb_i = 1'b0;
            cap(FRM + 1);
            bad = -1;
            for (int k = FRM; k >= 0; k--) if (txw[k] !== exp_tx(b, k)) bad = k;
            n_chk++; if (bad >= 0) begin n_fail++; $display("FAIL tx_wave byte %h at cycle %0d got %b want %b", b, bad, txw[bad], exp_tx(b, bad)); end
            bad = -1;
            for (int k = FRM; k >= 0; k--) if (bzw[k] !== (k < FRM)) bad = k;
            n_chk++; if (bad >= 0) begin n_fail++; $display("FAIL tx_busy at cycle %0d got %b want %b", bad, bzw[bad], bad < FRM); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b1, b2;
        int bad1, bad2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        as_data_i = b1;
        as_dstrb_i = 1'b1;
        @(posedge clk);
        #1 as_data_i = b2;
        cap(FRM + 1);
        bad1 = -1;
        for (int k = FRM; k >= 0; k--) if (txw[k] !== exp_tx(b1, k) || bzw[k] !== (k < FRM)) bad1 = k;
        @(posedge clk);
        #1 as_dstrb_i = 1'b0;
        cap(FRM + 1);
        bad2 = -1;
        for (int k = FRM; k >= 0; k--) if (txw[k] !== exp_tx(b2, k) || bzw[k] !== (k < FRM)) bad2 = k;
        n_chk++; if (bad1 >= 0) begin n_fail++; $display("FAIL b2b_first byte %h at cycle %0d got %b want %b", b1, bad1, txw[bad1], exp_tx(b1, bad1)); end
        n_chk++; if (bad2 >= 0) begin n_fail++; $display("FAIL b2b_second byte %h at cycle %0d got %b want %b", b2, bad2, txw[bad2], exp_tx(b2, bad2)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        int o0, g0;
        o0 = ovf_cnt;
        g0 = got.size();
        as_busy_i = 1'b1;
        rx_frame(8'h11, 0);
        rx_frame(8'h22, 0);
        rx_drive(1'b1, 16);
        n_chk++; if (as_data_o !== 8'h11) begin n_fail++; $display("FAIL ovf_held got %h want 11", as_data_o); end
        n_chk++; if (as_dstrb_o !== 1'b1) begin n_fail++; $display("FAIL ovf_dstrb got %b want 1", as_dstrb_o); end
        n_chk++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovf_pulse got %0d want 1", ovf_cnt - o0); end
        n_chk++; if (got.size() !== g0) begin n_fail++; $display("FAIL ovf_early_xfer got %0d want %0d", got.size(), g0); end
        as_busy_i = 1'b0;
        @(posedge clk);
        #1;
        n_chk++; if (as_dstrb_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drop got %b want 0", as_dstrb_o); end
        n_chk++; if (got.size() - g0 !== 1) begin n_fail++; $display("FAIL ovf_xfer_count got %0d want 1", got.size() - g0); end
        else begin
            n_chk++; if (got[got_rd] !== 8'h11) begin n_fail++; $display("FAIL ovf_xfer_data got %h want 11", got[got_rd]); end
        end
        got_rd = got.size();
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        int g0, f0;
        g0 = got.size();
        f0 = ferr_cnt;
        rx_drive(1'b0, 20);
        rx_drive(1'b1, 200);
        n_chk++; if (got.size() !== g0 || ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch got %0d events want 0", got.size() - g0 + ferr_cnt - f0); end
        b = 8'($urandom);
        rx_frame(b, 0);
        rx_drive(1'b1, 16);
        n_chk++; if (got.size() - g0 !== 1 || got[got.size()-1] !== b) begin n_fail++; $display("FAIL glitch_recover got %0d bytes want 1 of %h", got.size() - g0, b); end
        got_rd = got.size();
    endtask

    task automatic test_frame_err;
        int g0, f0, d0;
        g0 = got.size();
        f0 = ferr_cnt;
        d0 = dstrb_cnt;
        rx_frame(8'h55, 2);
        rx_drive(1'b1, 16);
        n_chk++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0); end
        n_chk++; if (dstrb_cnt !== d0) begin n_fail++; $display("FAIL ferr_dstrb got %0d want 0", dstrb_cnt - d0); end
        rx_frame(8'h0F, 0);
        rx_drive(1'b1, 16);
        n_chk++; if (got.size() - g0 !== 1 || got[got.size()-1] !== 8'h0F) begin n_fail++; $display("FAIL ferr_recover got %0d bytes want 1 of 0f", got.size() - g0); end
        got_rd = got.size();
    endtask

    task automatic test_simultaneous;
        logic [7:0] br, bt;
        int g0, bad;
        br = 8'($urandom);
        bt = 8'($urandom);
        g0 = got.size();
        fork
            rx_frame(br, 0);
            begin
                as_data_i = bt;
                as_dstrb_i = 1'b1;
                @(posedge clk);
                #1 as_dstrb_i = 1'b0;
                cap(FRM + 1);
            end
        join
        @(posedge clk);
        #1;
        rx_drive(1'b1, 16);
        bad = -1;
        for (int k = FRM; k >= 0; k--) if (txw[k] !== exp_tx(bt, k)) bad = k;
        n_chk++; if (bad >= 0) begin n_fail++; $display("FAIL sim_tx byte %h at cycle %0d got %b want %b", bt, bad, txw[bad], exp_tx(bt, bad)); end
        n_chk++; if (got.size() - g0 !== 1 || got[got.size()-1] !== br) begin n_fail++; $display("FAIL sim_rx got %0d bytes want 1 of %h", got.size() - g0, br); end
        got_rd = got.size();
    endtask

    task automatic test_reset_mid_tx;
        logic [7:0] b;
        int bad;
        as_data_i = 8'hFF;
        as_dstrb_i = 1'b1;
        @(posedge clk);
        #1 as_dstrb_i = 1'b0;
        repeat (4 * BIT + 20) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_chk++; if (as_busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b want 1", as_busy_o); end
        @(negedge clk);
        n_chk++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL rst_tx got %b want 1", tx_o); end
        n_chk++; if (as_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", as_busy_o); end
        @(posedge clk);
        #1 reset = 1'b0;
        b = 8'($urandom);
        as_data_i = b;
        as_dstrb_i = 1'b1;
        @(posedge clk);
        #1 as_dstrb_i = 1'b0;
        cap(FRM + 1);
        bad = -1;
        for (int k = FRM; k >= 0; k--) if (txw[k] !== exp_tx(b, k) || bzw[k] !== (k < FRM)) bad = k;
        n_chk++; if (bad >= 0) begin n_fail++; $display("FAIL rst_new_tx byte %h at cycle %0d got %b want %b", b, bad, txw[bad], exp_tx(b, bad)); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_rx_random();
        test_tx();
        test_back_to_back();
        test_overflow();
        test_glitch();
        test_frame_err();
        test_simultaneous();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
